// File: rtl/upc_checkout_tracker.sv
// upc_checkout_tracker: handshaked UPC scan classifier with theft alarm,
// 7-seg item letter and saturating tallies.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   scan_valid/ready    scan handshake (ready only in IDLE)
//   scan_upc/marked/returned  scanned item fields
//   clear               sync clear of all tallies
//   alarm_ack           alarm acknowledge (latch build only)
//   res_valid/discount/stolen  one-cycle result strobe + held flags
//   alarm               theft alarm
//   item_cnt/disc_cnt/stolen_cnt  saturating tallies
//   hex_item            active-low 7-seg code of last item
//
// Build option: define UPC_ALARM_LATCH_EN to hold the alarm until
// alarm_ack; otherwise the alarm lasts ALARM_CYCLES clocks.

module upc_checkout_tracker #(
  parameter int UPC_W = 3,
  parameter int CNT_W = 4,
  parameter logic [(1<<UPC_W)-1:0] DISC_MASK = 8'b1110_1100,
  parameter logic [(1<<UPC_W)-1:0] EXP_MASK  = 8'b1111_0101,
  parameter int ALARM_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_valid,
  output logic             scan_ready,
  input  logic [UPC_W-1:0] scan_upc,
  input  logic             scan_marked,
  input  logic             scan_returned,
  input  logic             clear,
  input  logic             alarm_ack,
  output logic             res_valid,
  output logic             res_discount,
  output logic             res_stolen,
  output logic             alarm,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic [CNT_W-1:0] stolen_cnt,
  output logic [6:0]       hex_item
);

  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_ALARM
  } state_t;

  state_t           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic             marked_q, marked_d;
  logic             returned_q, returned_d;
  logic             ready_q, ready_d;
  logic             res_valid_q, res_valid_d;
  logic             res_disc_q, res_disc_d;
  logic             res_stolen_q, res_stolen_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] item_q, item_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] stol_q, stol_d;
  logic [6:0]       hex_q, hex_d;
  logic [AW-1:0]    acnt_q, acnt_d;

  logic             eval_disc;
  logic             eval_stolen;
  logic [7:0]       code8;
  logic [6:0]       hex_dec;

`ifndef UPC_ALARM_LATCH_EN
  logic unused_ack;
  assign unused_ack = alarm_ack;
`endif

  assign eval_disc   = DISC_MASK[upc_q];
  assign eval_stolen = EXP_MASK[upc_q] & ~marked_q & ~returned_q;
  assign code8       = 8'(upc_q);

  always_comb begin
    hex_dec = HEX_DASH;
    unique case (1'b1)
      (code8 == 8'd0): hex_dec = 7'b0010010;
      (code8 == 8'd1): hex_dec = 7'b1110000;
      (code8 == 8'd2): hex_dec = 7'b1000000;
      (code8 == 8'd4): hex_dec = 7'b0000000;
      (code8 == 8'd5): hex_dec = 7'b1000110;
      (code8 == 8'd7): hex_dec = 7'b0001001;
      default:         hex_dec = HEX_DASH;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && (v != '1)) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d      = state_q;
    upc_d        = upc_q;
    marked_d     = marked_q;
    returned_d   = returned_q;
    res_valid_d  = 1'b0;
    res_disc_d   = res_disc_q;
    res_stolen_d = res_stolen_q;
    item_d       = item_q;
    disc_d       = disc_q;
    stol_d       = stol_q;
    hex_d        = hex_q;
    acnt_d       = acnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (scan_valid && ready_q) begin
          state_d    = S_EVAL;
          upc_d      = scan_upc;
          marked_d   = scan_marked;
          returned_d = scan_returned;
        end
      end
      S_EVAL: begin
        res_valid_d  = 1'b1;
        res_disc_d   = eval_disc;
        res_stolen_d = eval_stolen;
        hex_d        = hex_dec;
        item_d       = sat_inc(item_q, 1'b1);
        disc_d       = sat_inc(disc_q, eval_disc);
        stol_d       = sat_inc(stol_q, eval_stolen);
        if (eval_stolen) begin
          state_d = S_ALARM;
`ifndef UPC_ALARM_LATCH_EN
          // Counts remaining ALARM edges after this one.
          acnt_d  = AW'(ALARM_CYCLES - 1);
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ALARM: begin
`ifdef UPC_ALARM_LATCH_EN
        if (alarm_ack) state_d = S_IDLE;
`else
        if (acnt_q == '0) state_d = S_IDLE;
        else              acnt_d  = acnt_q - 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Clear beats a same-edge increment.
    if (clear) begin
      item_d = '0;
      disc_d = '0;
      stol_d = '0;
    end

    ready_d = (state_d == S_IDLE);
    alarm_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      upc_q        <= '0;
      marked_q     <= 1'b0;
      returned_q   <= 1'b0;
      ready_q      <= 1'b1;
      res_valid_q  <= 1'b0;
      res_disc_q   <= 1'b0;
      res_stolen_q <= 1'b0;
      alarm_q      <= 1'b0;
      item_q       <= '0;
      disc_q       <= '0;
      stol_q       <= '0;
      hex_q        <= HEX_BLANK;
      acnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      upc_q        <= upc_d;
      marked_q     <= marked_d;
      returned_q   <= returned_d;
      ready_q      <= ready_d;
      res_valid_q  <= res_valid_d;
      res_disc_q   <= res_disc_d;
      res_stolen_q <= res_stolen_d;
      alarm_q      <= alarm_d;
      item_q       <= item_d;
      disc_q       <= disc_d;
      stol_q       <= stol_d;
      hex_q        <= hex_d;
      acnt_q       <= acnt_d;
    end
  end

  assign scan_ready   = ready_q;
  assign res_valid    = res_valid_q;
  assign res_discount = res_disc_q;
  assign res_stolen   = res_stolen_q;
  assign alarm        = alarm_q;
  assign item_cnt     = item_q;
  assign disc_cnt     = disc_q;
  assign stolen_cnt   = stol_q;
  assign hex_item     = hex_q;

endmodule

// File: tb/tb_upc_checkout_tracker.sv
// tb_upc_checkout_tracker: directed + randomized scans against a
// transaction-level reference model of the checkout tracker.

module tb_upc_checkout_tracker;

  localparam int ALARM_CYCLES = 8;
  localparam int CMAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_valid;
  logic       scan_ready;
  logic [2:0] scan_upc;
  logic       scan_marked;
  logic       scan_returned;
  logic       clear;
  logic       alarm_ack;
  logic       res_valid;
  logic       res_discount;
  logic       res_stolen;
  logic       alarm;
  logic [3:0] item_cnt;
  logic [3:0] disc_cnt;
  logic [3:0] stolen_cnt;
  logic [6:0] hex_item;

  upc_checkout_tracker #(
    .UPC_W(3),
    .CNT_W(4),
    .DISC_MASK(8'b1110_1100),
    .EXP_MASK(8'b1111_0101),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_valid(scan_valid),
    .scan_ready(scan_ready),
    .scan_upc(scan_upc),
    .scan_marked(scan_marked),
    .scan_returned(scan_returned),
    .clear(clear),
    .alarm_ack(alarm_ack),
    .res_valid(res_valid),
    .res_discount(res_discount),
    .res_stolen(res_stolen),
    .alarm(alarm),
    .item_cnt(item_cnt),
    .disc_cnt(disc_cnt),
    .stolen_cnt(stolen_cnt),
    .hex_item(hex_item)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] disc_tab = 8'b1110_1100;
  logic [7:0] exp_tab  = 8'b1111_0101;

  int         m_item, m_disc, m_stol;
  logic [6:0] m_hex;
  bit         m_rd, m_rs;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex_of(input int code);
    case (code)
      0: return 7'b0010010;
      1: return 7'b1110000;
      2: return 7'b1000000;
      4: return 7'b0000000;
      5: return 7'b1000110;
      7: return 7'b0001001;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic int sat(input int v, input bit en);
    if (!en) return v;
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic chk_cnts(input string tag);
    chk({tag, "_item"}, 32'(item_cnt), 32'(m_item));
    chk({tag, "_disc"}, 32'(disc_cnt), 32'(m_disc));
    chk({tag, "_stol"}, 32'(stolen_cnt), 32'(m_stol));
  endtask

  task automatic model_reset();
    m_item = 0; m_disc = 0; m_stol = 0;
    m_hex = 7'b1111111; m_rd = 0; m_rs = 0;
  endtask

  task automatic alarm_phase();
`ifdef UPC_ALARM_LATCH_EN
    scan_valid = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      chk("alm_hold", alarm, 1'b1);
      chk("alm_rdy", scan_ready, 1'b0);
      chk("alm_rv", res_valid, 1'b0);
      chk("alm_item", 32'(item_cnt), 32'(m_item));
    end
    scan_valid = 1'b0;
    alarm_ack  = 1'b1;
    @(posedge clk); #1;
    alarm_ack = 1'b0;
    chk("alm_ack_off", alarm, 1'b0);
    chk("alm_ack_rdy", scan_ready, 1'b1);
`else
    scan_valid = 1'b1;
    alarm_ack  = 1'b1;
    repeat (ALARM_CYCLES - 1) begin
      @(posedge clk); #1;
      chk("alm_hold", alarm, 1'b1);
      chk("alm_rdy", scan_ready, 1'b0);
      chk("alm_rv", res_valid, 1'b0);
      chk("alm_item", 32'(item_cnt), 32'(m_item));
    end
    @(posedge clk); #1;
    scan_valid = 1'b0;
    alarm_ack  = 1'b0;
    chk("alm_off", alarm, 1'b0);
    chk("alm_off_rdy", scan_ready, 1'b1);
    chk("alm_off_item", 32'(item_cnt), 32'(m_item));
`endif
  endtask

  task automatic do_scan(input int upc, input bit mk, input bit rt,
                         input bit clr);
    bit d;
    bit s;
    d = disc_tab[upc];
    s = exp_tab[upc] && !mk && !rt;
    chk("rdy_pre", scan_ready, 1'b1);
    scan_valid    = 1'b1;
    scan_upc      = 3'(upc);
    scan_marked   = mk;
    scan_returned = rt;
    @(posedge clk); #1;
    scan_valid    = 1'b0;
    scan_upc      = 3'($urandom_range(0, 7));
    scan_marked   = 1'($urandom_range(0, 1));
    scan_returned = 1'($urandom_range(0, 1));
    chk("rdy_eval", scan_ready, 1'b0);
    chk("rv_eval", res_valid, 1'b0);
    chk("alm_eval", alarm, 1'b0);
    clear = clr;
    @(posedge clk); #1;
    clear = 1'b0;
    if (clr) begin
      m_item = 0; m_disc = 0; m_stol = 0;
    end else begin
      m_item = sat(m_item, 1'b1);
      m_disc = sat(m_disc, d);
      m_stol = sat(m_stol, s);
    end
    m_hex = hex_of(upc);
    m_rd  = d;
    m_rs  = s;
    chk("rv", res_valid, 1'b1);
    chk("res_disc", res_discount, m_rd);
    chk("res_stol", res_stolen, m_rs);
    chk("hex", 32'(hex_item), 32'(m_hex));
    chk("alarm", alarm, s);
    chk("rdy_post", scan_ready, !s);
    chk_cnts("cnt");
    if (s) alarm_phase();
  endtask

  initial begin
    rst_n = 1'b0;
    scan_valid = 1'b0; scan_upc = '0;
    scan_marked = 1'b0; scan_returned = 1'b0;
    clear = 1'b0; alarm_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", scan_ready, 1'b1);
    chk("rst_rv", res_valid, 1'b0);
    chk("rst_rd", res_discount, 1'b0);
    chk("rst_rs", res_stolen, 1'b0);
    chk("rst_alm", alarm, 1'b0);
    chk("rst_hex", 32'(hex_item), 32'h7f);
    chk_cnts("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_scan(0, 1'b0, 1'b1, 1'b0);
    do_scan(5, 1'b0, 1'b0, 1'b0);
    chk("t2_stol", 32'(stolen_cnt), 32'd1);

    // alarm_ack outside ALARM must do nothing
    alarm_ack = 1'b1;
    @(posedge clk); #1;
    alarm_ack = 1'b0;
    chk("ack_idle_rdy", scan_ready, 1'b1);
    chk("ack_idle_alm", alarm, 1'b0);

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset_cnts();
    chk_cnts("clr_idle");
    chk("clr_hex", 32'(hex_item), 32'(m_hex));

    repeat (20) do_scan(2, 1'b1, 1'b0, 1'b0);
    chk("sat_item", 32'(item_cnt), 32'd15);
    chk("sat_disc", 32'(disc_cnt), 32'd15);

    do_scan(3, 1'b0, 1'b0, 1'b1);
    chk("clr_eval_hex", 32'(hex_item), 32'h3f);

    // reset asserted while a stolen scan is in EVAL
    scan_valid = 1'b1; scan_upc = 3'd5;
    scan_marked = 1'b0; scan_returned = 1'b0;
    @(posedge clk); #1;
    scan_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rdy", scan_ready, 1'b1);
    chk("mid_rst_alm", alarm, 1'b0);
    chk("mid_rst_hex", 32'(hex_item), 32'(m_hex));
    rst_n = 1'b1;
    #2;
    @(posedge clk); #1;
    chk("post_rst_rv", res_valid, 1'b0);
    chk("post_rst_alm", alarm, 1'b0);
    chk("post_rst_rdy", scan_ready, 1'b1);
    chk_cnts("post_rst");

    for (int i = 0; i < 60; i++) begin
      do_scan(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("idle_rv", res_valid, 1'b0);
        chk("idle_rs", res_stolen, m_rs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic model_reset_cnts();
    m_item = 0; m_disc = 0; m_stol = 0;
  endtask

endmodule

// File: doc/upc_checkout_tracker.md
# upc_checkout_tracker

Sequential, parametrised successor to the combinational item-code decoder on the DE1-SoC checkout-station board. Accepts one scanned UPC per handshake, classifies it as discounted and/or stolen using per-code mask parameters, drives a 7-segment item letter, and keeps saturating tallies of items, discounts and thefts. A stolen item raises an alarm that blocks further scans until it expires or, optionally, until it is acknowledged. Sits between the switch/key debounce logic and the HEX/LEDR drivers in the top level.

## Interface

- UPC_W, 3, width of the UPC item code (1..8)
- CNT_W, 4, width of each tally counter
- DISC_MASK, 8'b1110_1100 (width 2**UPC_W), bit i set = code i is a discounted item
- EXP_MASK, 8'b1111_0101 (width 2**UPC_W), bit i set = code i is an expensive item (stolen if unmarked and not returned)
- ALARM_CYCLES, 8, alarm hold length in clocks (≥1), used when the latch feature is compiled out

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- scan_valid  in  1  scan offered
- scan_ready  out  1  block can accept a scan
- scan_upc  in  UPC_W  item code
- scan_marked  in  1  item carries a discount mark
- scan_returned  in  1  item is a return
- clear  in  1  synchronous clear of all tallies
- alarm_ack  in  1  alarm acknowledge (latch mode only)
- res_valid  out  1  one-cycle result strobe
- res_discount  out  1  last accepted item is discounted
- res_stolen  out  1  last accepted item is stolen
- alarm  out  1  theft alarm
- item_cnt / disc_cnt / stolen_cnt  out  CNT_W each  saturating tallies
- hex_item  out  7  active-low segment code of the last accepted item

## Operation

- FSM states: IDLE, EVAL, ALARM. scan_ready = (state == IDLE).
- IDLE: on scan_valid & scan_ready, register upc/marked/returned and go to EVAL.
- EVAL (exactly one cycle):
  - discount = DISC_MASK[upc]
  - stolen = EXP_MASK[upc] & ~marked & ~returned
  - On exit edge: res_valid=1, res_* loaded, hex_item loaded, item_cnt+1, disc_cnt+discount, stolen_cnt+stolen.
  - Next state is ALARM if stolen, else IDLE.
- ALARM: alarm=1, scan_ready=0. Exit per Configuration, then return to IDLE.
- hex_item table (active-low):
  - 0 → 7'b0010010 (S)
  - 1 → 7'b1110000 (J)
  - 2 → 7'b1000000 (O)
  - 4 → 7'b0000000 (B)
  - 5 → 7'b1000110 (C)
  - 7 → 7'b0001001 (K)
  - All other codes, including any code ≥8 → 7'b0111111 (dash).
- Counters saturate at 2**CNT_W−1 and never wrap.
- clear and an increment on the same edge: clear wins, and the counter reads 0.
- clear affects counters only; it does not change FSM state, alarm or hex_item.
- alarm_ack is ignored outside ALARM.
- scan_valid while scan_ready=0 is ignored; no buffering.

## Timing

- Reset values:
  - state=IDLE
  - scan_ready=1
  - res_valid=0, res_discount=0, res_stolen=0
  - alarm=0
  - all counters 0
  - hex_item=7'b1111111 (blank)
- Handshake at edge k → res_valid high for the cycle after edge k+1. Result latency is 2 edges.
- Non-stolen scan: scan_ready low for exactly one cycle; maximum throughput is one scan per 2 cycles.
- Stolen scan: alarm rises at edge k+1 and scan_ready stays low until ALARM exits.
- res_discount, res_stolen and hex_item hold until the next result.
- Reset asserted mid-operation: all state returns to reset values immediately, and any in-flight scan is discarded.

## Configuration

- UPC_ALARM_LATCH_EN defined:
  - ALARM exits only on the edge where alarm_ack=1.
  - alarm falls and scan_ready rises on that edge.
  - ALARM_CYCLES is unused.
- UPC_ALARM_LATCH_EN undefined:
  - ALARM lasts exactly ALARM_CYCLES cycles, so alarm falls at edge k+1+ALARM_CYCLES.
  - alarm_ack is ignored.

## Test plan

- Reset, then scan upc=0, marked=0, returned=1 → res_valid pulse 2 edges after handshake; discount=0, stolen=0; hex_item=7'b0010010; item_cnt=1.
- Scan upc=5, marked=0, returned=0 → discount=1, stolen=1, alarm=1; with the macro undefined, alarm falls after 8 cycles; stolen_cnt=1, disc_cnt=1.
- Macro defined: same stolen scan → alarm holds 50 cycles with scan_valid asserted and no acceptance; alarm_ack pulse → alarm=0 and scan_ready=1 on the same edge.
- 20 back-to-back non-stolen scans of upc=2 with CNT_W=4 → item_cnt and disc_cnt saturate at 15; scan_ready toggles 1,0.
- clear asserted on the EVAL-exit edge of a scan of upc=3 → all counters 0 afterwards; hex_item=7'b0111111; res_valid still pulses.
- rst_n pulsed low during EVAL of a stolen scan → no res_valid, alarm stays 0, counters 0, scan_ready=1 after release.
